// File: rtl/fir_interp4.sv
// 1:4 polyphase FIR interpolator built around a single shared multiplier.
// Each accepted sample produces four outputs, one per phase p, computed as
// sum_k h[4k+p] * d[k] over L = taps/4 taps, one product per clock.
module fir_interp4 #(
  parameter int unsigned taps        = 32,
  parameter int unsigned num_bits    = 8,
  parameter int unsigned input_size  = 8,
  parameter int unsigned output_size = 2 * num_bits + $clog2(taps / 4)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [input_size-1:0]   Data_In,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [output_size-1:0]  Data_Out,
  output logic [1:0]              out_phase,
  input  logic                    coef_we,
  input  logic [$clog2(taps)-1:0] coef_addr,
  input  logic [num_bits-1:0]     coef_data,
  output logic                    busy
);

  localparam int unsigned L  = taps / 4;
  localparam int unsigned LW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned AW = $clog2(taps);
  localparam int unsigned PW = num_bits + input_size;
  localparam logic [LW-1:0] LastTap = LW'(L - 1);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                 r_state;
  logic [num_bits-1:0]    r_coef [taps];
  logic [input_size-1:0]  r_dline [L];
  logic [1:0]             r_phase;
  logic [LW-1:0]          r_tap;
  logic [output_size-1:0] r_acc;
  logic [output_size-1:0] r_data_out;
  logic                   r_out_valid;
  logic [1:0]             r_out_phase;

  logic                   w_idle;
  logic                   w_accept;
  logic                   w_coef_wr;
  logic [AW-1:0]          w_cidx;
  logic [PW-1:0]          w_prod;
  logic [output_size-1:0] w_sum;

  assign w_idle    = (r_state == StIdle);
  assign w_accept  = in_valid && w_idle;
  // Coefficient writes only land while idle and not racing an input accept.
  assign w_coef_wr = coef_we && w_idle && !w_accept;
  // {tap, phase} is exactly 4*tap + phase.
  assign w_cidx    = AW'({r_tap, r_phase});
  assign w_prod    = PW'(r_coef[w_cidx]) * PW'(r_dline[r_tap]);
  assign w_sum     = r_acc + output_size'(w_prod);

  assign in_ready  = w_idle;
  assign busy      = !w_idle;
  assign out_valid = r_out_valid;
  assign Data_Out  = r_data_out;
  assign out_phase = r_out_phase;

  // Coefficient memory: cleared on reset, written from the config port when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < taps; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // Delay line: shifts only when a new sample is accepted, d[0] is newest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) r_dline[i] <= '0;
    end else if (w_accept) begin
      r_dline[0] <= Data_In;
      for (int i = 1; i < L; i++) r_dline[i] <= r_dline[i-1];
    end
  end

  // Control FSM: MAC one tap per cycle, then hold the result until handshaked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_phase     <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_out_phase <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_phase <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          if (r_tap == LastTap) begin
            r_data_out  <= w_sum;
            r_out_valid <= 1'b1;
            r_out_phase <= r_phase;
            r_state     <= StOut;
          end else begin
            r_acc <= w_sum;
            r_tap <= r_tap + 1'b1;
          end
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_phase != 2'd3) begin
              r_phase <= r_phase + 2'd1;
              r_tap   <= '0;
              r_acc   <= '0;
              r_state <= StMac;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp4.sv
// Self-checking bench for fir_interp4 with a behavioural polyphase model.
module tb_fir_interp4;

  localparam int Taps = 32;
  localparam int L    = Taps / 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  Data_In = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] Data_Out;
  logic [1:0]  out_phase;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [7:0]  coef_data = '0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int unsigned m_h[Taps];
  int unsigned m_d[L];

  int unsigned g_out[4];
  int          g_ph[4];
  int          g_lat;
  bit          g_tmo;

  fir_interp4 #(
    .taps(32), .num_bits(8), .input_size(8), .output_size(19)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Data_In  (Data_In),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Data_Out (Data_Out),
    .out_phase(out_phase),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Reference model
  task automatic model_clear();
    for (int i = 0; i < Taps; i++) m_h[i] = 0;
    for (int k = 0; k < L; k++) m_d[k] = 0;
  endtask

  task automatic model_accept(input int unsigned din);
    for (int k = L - 1; k > 0; k--) m_d[k] = m_d[k-1];
    m_d[0] = din;
  endtask

  function automatic int unsigned model_out(input int p);
    int unsigned s;
    s = 0;
    for (int k = 0; k < L; k++) s += m_h[4*k + p] * m_d[k];
    return s;
  endfunction

  task automatic write_coef(input int addr, input int unsigned val);
    coef_we   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = 8'(val);
    @(negedge clock);
    coef_we = 1'b0;
    m_h[addr] = val;
  endtask

  // Accepts one sample and collects its four outputs with out_ready held high.
  // mode 1: coefficient write on the accept edge; mode 2: write during MAC.
  task automatic do_burst(input logic [7:0] din, input int mode);
    int n, c, w;
    g_tmo = 0; n = 0; c = 0; w = 0; g_lat = -1;
    while (!in_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      g_tmo = 1;
      return;
    end
    in_valid = 1'b1;
    Data_In  = din;
    if (mode == 1) begin
      coef_we = 1'b1; coef_addr = '0; coef_data = 8'd9;
    end
    @(negedge clock);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    model_accept(din);
    if (mode == 2) begin
      coef_we = 1'b1; coef_addr = '0; coef_data = 8'd9;
    end
    while (n < 4 && c < 200) begin
      if (out_valid) begin
        g_out[n] = Data_Out;
        g_ph[n]  = out_phase;
        if (n == 0) g_lat = c;
        n++;
      end
      @(negedge clock);
      c++;
      coef_we = 1'b0;
    end
    if (n < 4) g_tmo = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || Data_Out !== 19'd0 || out_phase !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b data=%0d phase=%0d need 0/0/0",
               out_valid, Data_Out, out_phase);
    end
    reset = 1'b1;
    model_clear();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b busy=%b need 1/0", in_ready, busy);
    end
    @(negedge clock);
  endtask

  task automatic test_impulse();
    for (int i = 0; i < Taps; i++) write_coef(i, i + 1);
    for (int b = 0; b < 8; b++) begin
      do_burst((b == 0) ? 8'd1 : 8'd0, 0);
      n_cmp++;
      if (g_tmo) begin
        n_err++;
        $display("FAIL impulse_timeout: burst %0d did not complete", b);
      end
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (g_out[p] !== 4*b + p + 1 || g_ph[p] !== p) begin
          n_err++;
          $display("FAIL impulse_out: burst %0d idx %0d got %0d ph %0d need %0d ph %0d",
                   b, p, g_out[p], g_ph[p], 4*b + p + 1, p);
        end
      end
    end
    n_cmp++;
    if (g_lat !== L) begin
      n_err++;
      $display("FAIL impulse_latency: got %0d need %0d", g_lat, L);
    end
  endtask

  task automatic test_throughput();
    int unsigned q_exp[$];
    int          q_ph[$];
    int  n_acc, last_acc, guard;
    bit  chg, first_pend;
    n_acc = 0; last_acc = 0; guard = 0; chg = 0; first_pend = 0;
    in_valid = 1'b1;
    Data_In  = 8'($urandom);
    while (guard < 600 && (n_acc < 4 || q_exp.size() > 0)) begin
      n_cmp++;
      if (busy !== !in_ready) begin
        n_err++;
        $display("FAIL tput_busy: got busy=%b in_ready=%b", busy, in_ready);
      end
      if (out_valid) begin
        n_cmp++;
        if (q_exp.size() == 0) begin
          n_err++;
          $display("FAIL tput_extra: unexpected output %0d", Data_Out);
        end else begin
          if (Data_Out !== 19'(q_exp[0]) || out_phase !== 2'(q_ph[0])) begin
            n_err++;
            $display("FAIL tput_out: got %0d ph %0d need %0d ph %0d",
                     Data_Out, out_phase, q_exp[0], q_ph[0]);
          end
          void'(q_exp.pop_front());
          void'(q_ph.pop_front());
        end
        if (first_pend) begin
          first_pend = 0;
          n_cmp++;
          if (cyc - last_acc - 1 !== L) begin
            n_err++;
            $display("FAIL tput_latency: got %0d need %0d", cyc - last_acc - 1, L);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (n_acc > 0) begin
          n_cmp++;
          if (cyc - last_acc !== 4*(L+1) + 1) begin
            n_err++;
            $display("FAIL tput_period: got %0d need %0d", cyc - last_acc, 4*(L+1) + 1);
          end
        end
        model_accept(Data_In);
        for (int p = 0; p < 4; p++) begin
          q_exp.push_back(model_out(p));
          q_ph.push_back(p);
        end
        last_acc = cyc; n_acc++; chg = 1; first_pend = 1;
      end
      @(negedge clock);
      guard++;
      if (chg) begin
        chg = 0;
        if (n_acc == 4) in_valid = 1'b0;
        else Data_In = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_acc != 4 || q_exp.size() != 0) begin
      n_err++;
      $display("FAIL tput_count: got %0d accepts %0d pending need 4/0", n_acc, q_exp.size());
    end
  endtask

  task automatic test_backpressure();
    int unsigned e[4];
    int n, c, extra;
    bit done_bp;
    logic [18:0] hold_d;
    logic [1:0]  hold_p;
    for (int i = 0; i < Taps; i++) write_coef(i, $urandom_range(255));
    in_valid = 1'b1;
    Data_In  = 8'($urandom_range(255, 1));
    @(negedge clock);
    in_valid = 1'b0;
    model_accept(Data_In);
    for (int p = 0; p < 4; p++) e[p] = model_out(p);
    n = 0; c = 0; done_bp = 0; extra = 0;
    while (n < 4 && c < 300) begin
      if (out_valid) begin
        if (out_phase == 2'd1 && !done_bp) begin
          done_bp = 1;
          out_ready = 1'b0;
          hold_d = Data_Out;
          hold_p = out_phase;
          for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            c++;
            n_cmp++;
            if (out_valid !== 1'b1 || Data_Out !== hold_d || out_phase !== hold_p) begin
              n_err++;
              $display("FAIL bp_hold: got v=%b d=%0d ph=%0d need 1/%0d/%0d",
                       out_valid, Data_Out, out_phase, hold_d, hold_p);
            end
          end
          out_ready = 1'b1;
        end
        n_cmp++;
        if (Data_Out !== 19'(e[n]) || out_phase !== 2'(n)) begin
          n_err++;
          $display("FAIL bp_out: idx %0d got %0d ph %0d need %0d ph %0d",
                   n, Data_Out, out_phase, e[n], n);
        end
        n++;
      end
      @(negedge clock);
      c++;
    end
    n_cmp++;
    if (n != 4 || !done_bp) begin
      n_err++;
      $display("FAIL bp_count: got %0d outputs stalled=%0d need 4/1", n, done_bp);
    end
    for (int j = 0; j < 30; j++) begin
      if (out_valid) extra++;
      @(negedge clock);
    end
    n_cmp++;
    if (extra != 0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_extra: got %0d extra in_ready=%b need 0/1", extra, in_ready);
    end
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < Taps; i++) write_coef(i, 255);
    for (int b = 0; b < 8; b++) begin
      do_burst(8'd255, 0);
      n_cmp++;
      if (g_tmo) begin
        n_err++;
        $display("FAIL full_timeout: burst %0d", b);
      end
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (g_out[p] !== model_out(p)) begin
          n_err++;
          $display("FAIL full_model: burst %0d ph %0d got %0d need %0d",
                   b, p, g_out[p], model_out(p));
        end
        if (b == 7) begin
          n_cmp++;
          if (g_out[p] !== 520200) begin
            n_err++;
            $display("FAIL full_scale: ph %0d got %0d need 520200", p, g_out[p]);
          end
        end
      end
    end
  endtask

  task automatic test_busy_write();
    for (int i = 0; i < Taps; i++) write_coef(i, i + 1);
    do_burst(8'd0, 1);
    do_burst(8'd0, 2);
    for (int b = 0; b < 6; b++) do_burst(8'd0, 0);
    do_burst(8'd1, 0);
    n_cmp++;
    if (g_tmo) begin
      n_err++;
      $display("FAIL busy_timeout: impulse burst");
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (g_out[p] !== p + 1) begin
        n_err++;
        $display("FAIL busy_write: ph %0d got %0d need %0d", p, g_out[p], p + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, q;
    bit found;
    for (int i = 0; i < Taps; i++) write_coef(i, $urandom_range(255, 1));
    in_valid = 1'b1;
    Data_In  = 8'($urandom_range(255, 1));
    @(negedge clock);
    in_valid = 1'b0;
    c = 0; found = 0;
    while (!found && c < 200) begin
      if (out_valid && out_phase == 2'd1) found = 1;
      @(negedge clock);
      c++;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rstmid_timeout: phase 1 output not seen");
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Data_Out !== 19'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b rdy=%b d=%0d need 0/1/0",
               out_valid, in_ready, Data_Out);
    end
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_release: got rdy=%b busy=%b need 1/0", in_ready, busy);
    end
    q = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clock);
      if (out_valid) q++;
    end
    n_cmp++;
    if (q != 0) begin
      n_err++;
      $display("FAIL rstmid_partial: got %0d stray outputs need 0", q);
    end
    do_burst(8'($urandom_range(255, 1)), 0);
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (g_tmo || g_out[p] !== 0 || g_ph[p] !== p) begin
        n_err++;
        $display("FAIL rstmid_zero: ph %0d got %0d (tmo %0d) need 0", p, g_out[p], g_tmo);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < Taps; i++) write_coef(i, $urandom_range(255));
    for (int b = 0; b < 12; b++) begin
      do_burst(8'($urandom), 0);
      n_cmp++;
      if (g_tmo) begin
        n_err++;
        $display("FAIL rand_timeout: burst %0d", b);
      end
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (g_out[p] !== model_out(p) || g_ph[p] !== p) begin
          n_err++;
          $display("FAIL rand_out: burst %0d ph %0d got %0d/%0d need %0d/%0d",
                   b, p, g_out[p], g_ph[p], model_out(p), p);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clock);
    test_reset();
    test_impulse();
    test_throughput();
    test_backpressure();
    test_full_scale();
    test_busy_write();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
